rdp_row_recover: RTL
====================

RDP_ROW_RECOVER -- requirements
Module: rdp_row_recover

Interface
REQ-001 SHALL have parameter SLICES, default 4: number of data slices per beat.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: bits per slice; bus width W = SLICES*DATA_WIDTH.
REQ-003 SHALL have parameter NCOLS, default 6: number of beats in a complete stripe (surviving data columns plus row parity).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port t_dat, input, W: surviving column or row-parity beat.
REQ-007 SHALL have port t_valid, input, 1: t_dat/t_last valid.
REQ-008 SHALL have port t_last, input, 1: final beat of the stripe.
REQ-009 SHALL have port t_ready, output, 1: block accepts a beat.
REQ-010 SHALL have port i_dat, output, W: recovered (missing) column.
REQ-011 SHALL have port i_valid, output, 1: i_dat/i_err valid.
REQ-012 SHALL have port i_err, output, 1: stripe beat count was not NCOLS.
REQ-013 SHALL have port i_ready, input, 1: downstream accepts the result.
REQ-014 SHALL have port i_stripes, output, 16: count of results delivered.

Function
REQ-015 SHALL implement two states, ACC and OUT; reset state ACC.
REQ-016 SHALL drive t_ready = 1 in ACC and 0 in OUT, with no combinational path from i_ready.
REQ-017 SHALL accept a beat only on t_valid & t_ready; t_dat and t_last are ignored otherwise.
REQ-018 On an accepted beat with beat counter cnt==0, the accumulator SHALL load t_dat; otherwise it SHALL load acc ^ t_dat.
REQ-019 SHALL increment cnt per accepted non-last beat, saturating at NCOLS; cnt width is clog2(NCOLS+1).
REQ-020 On an accepted beat with t_last=1, SHALL register i_dat = acc ^ t_dat (t_dat if cnt==0), set i_valid=1, clear cnt, and go to OUT.
REQ-021 On the t_last beat, SHALL set i_err=1 when the total beats in the stripe (saturated cnt+1) differs from NCOLS, else 0.
REQ-022 i_valid SHALL rise the cycle after the last beat is accepted (latency 1).
REQ-023 In OUT, SHALL hold i_valid, i_dat and i_err stable until i_valid & i_ready.
REQ-024 On i_valid & i_ready, SHALL clear i_valid, return to ACC, and increment i_stripes (wrapping 0xFFFF->0x0000).
REQ-025 Throughput SHALL be one stripe per NCOLS+1 cycles minimum, with one idle t_ready cycle per stripe while OUT is handshaked.
REQ-026 After handshake, i_dat and i_err SHALL retain their last values while i_valid=0.
REQ-027 A beat presented while in OUT SHALL stall (t_ready=0) and must be held by the sender.

Reset
REQ-028 While reset_n=0 at a clock edge: state=ACC, cnt=0, acc=0, i_dat=0, i_valid=0, i_err=0, i_stripes=0; t_ready=1 after the edge.
REQ-029 Reset mid-stripe or in OUT SHALL discard the partial accumulation and pending result; the first beat after reset starts a new stripe.

Verification (SLICES=2, DATA_WIDTH=8, NCOLS=4)
REQ-030 Nominal: beats 0x0102, 0x0304, 0x0508, 0x0F00 (last), i_ready=1 -> next cycle i_valid=1, i_dat=0x080E, i_err=0; i_stripes=1 after handshake.
REQ-031 Backpressure: the same stripe with i_ready=0 for 5 cycles -> i_valid=1, i_dat=0x080E stable, t_ready=0 throughout; release -> one handshake, t_ready=1 next cycle.
REQ-032 Short stripe: beats 0x00FF, 0xFF00, 0x1111 (last) -> i_dat=0xEEEE, i_err=1.
REQ-033 Long stripe: 6 beats of 0x0001 with t_last on beat 6 -> i_dat=0x0000, i_err=1, cnt saturated with no wrap.
REQ-034 Reset mid-stripe: 2 beats, then reset_n=0 for 1 cycle, then the REQ-030 stripe -> i_dat=0x080E, i_err=0, i_stripes=1.
REQ-035 Counter wrap: preload by running 65536 stripes -> i_stripes reads 0x0000, with no other side effects.

Source files
------------

// File: rtl/rdp_row_recover.sv
// Row-parity recovery: XORs the surviving columns and the row parity of one stripe
// to rebuild the missing column, then holds the result until downstream takes it.
module rdp_row_recover #(
    parameter int unsigned SLICES     = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NCOLS      = 6,
    localparam int unsigned W         = SLICES * DATA_WIDTH,
    localparam int unsigned CW        = $clog2(NCOLS + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [W-1:0]  t_dat,
    input  logic          t_valid,
    input  logic          t_last,
    output logic          t_ready,
    output logic [W-1:0]  i_dat,
    output logic          i_valid,
    output logic          i_err,
    input  logic          i_ready,
    output logic [15:0]   i_stripes
);

    typedef enum logic [0:0] {StAcc, StOut} state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   dat_q, dat_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [15:0]    stripes_q, stripes_d;

    logic           accept;
    logic [W-1:0]   beat_x;

    assign accept = t_valid && (state_q == StAcc);
    // First beat of a stripe replaces the accumulator instead of XORing into stale data.
    assign beat_x = (cnt_q == '0) ? t_dat : (acc_q ^ t_dat);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dat_d     = dat_q;
        valid_d   = valid_q;
        err_d     = err_q;
        stripes_d = stripes_q;

        if (accept) begin
            acc_d = beat_x;
            if (t_last) begin
                dat_d   = beat_x;
                valid_d = 1'b1;
                // cnt saturates at NCOLS, so only cnt == NCOLS-1 means exactly NCOLS beats.
                err_d   = (cnt_q != CW'(NCOLS - 1));
                cnt_d   = '0;
                state_d = StOut;
            end else if (cnt_q != CW'(NCOLS)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        if ((state_q == StOut) && i_ready) begin
            valid_d   = 1'b0;
            state_d   = StAcc;
            stripes_d = stripes_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StAcc;
            cnt_q     <= '0;
            acc_q     <= '0;
            dat_q     <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            stripes_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dat_q     <= dat_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            stripes_q <= stripes_d;
        end
    end

    assign t_ready   = (state_q == StAcc);
    assign i_dat     = dat_q;
    assign i_valid   = valid_q;
    assign i_err     = err_q;
    assign i_stripes = stripes_q;

endmodule
